// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the main-memory arbiter.
//   arb_state_e : arbiter FSM states (2-bit)
//   arb_port_e  : requester IDs (icache / dcache)
//   rr_pick     : round-robin winner selection
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbBusyI = 2'd1,
        ArbBusyD = 2'd2,
        ArbCool  = 2'd3
    } arb_state_e;

    typedef enum logic {
        ArbPortI = 1'b0,
        ArbPortD = 1'b1
    } arb_port_e;

    // A lone requester always wins; on a tie the port that did not win last time goes.
    function automatic arb_port_e rr_pick(input logic ic_req, input logic dc_req,
                                          input arb_port_e last);
        arb_port_e win;
        if (ic_req && dc_req) begin
            win = (last == ArbPortD) ? ArbPortI : ArbPortD;
        end else if (ic_req) begin
            win = ArbPortI;
        end else begin
            win = ArbPortD;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one LINE_W-wide main-memory port between the icache controller
// (read-only) and the dcache controller (read/write). Round-robin, one transaction in
// flight, one dead cycle after every completion.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ic_enable_i/ic_addr_i        icache request (held until ic_ack_o)
//   ic_data_o/ic_ack_o           icache read data / one-cycle completion pulse
//   dc_enable_i/dc_write_i       dcache request / write flag (held until dc_ack_o)
//   dc_addr_i/dc_data_i          dcache address / write data
//   dc_data_o/dc_ack_o           dcache read data / one-cycle completion pulse
//   mem_enable_o/mem_write_o     memory request / write, straight from flops
//   mem_addr_o/mem_data_o        latched address / write data
//   mem_data_i/mem_ack_i         memory read data / completion pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ic_enable_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic [LINE_W-1:0] ic_data_o,
    output logic              ic_ack_o,

    input  logic              dc_enable_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_data_i,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              dc_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_e        state_q;
    arb_port_e         last_grant_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;

    logic              any_req;
    arb_port_e         winner;

    always_comb begin
        any_req = ic_enable_i | dc_enable_i;
        winner  = rr_pick(ic_enable_i, dc_enable_i, last_grant_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ArbIdle;
            last_grant_q <= ArbPortD;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (any_req) begin
                        last_grant_q <= winner;
                        if (winner == ArbPortD) begin
                            state_q     <= ArbBusyD;
                            mem_addr_q  <= dc_addr_i;
                            mem_data_q  <= dc_data_i;
                            mem_write_q <= dc_write_i;
                        end else begin
                            // icache reads leave the write-data flops untouched
                            state_q     <= ArbBusyI;
                            mem_addr_q  <= ic_addr_i;
                            mem_write_q <= 1'b0;
                        end
                    end
                end
                ArbBusyI, ArbBusyD: begin
                    if (mem_ack_i) begin
                        state_q <= ArbCool;
                    end
                end
                // Dead cycle: enables are ignored so a requester that drops its enable
                // one cycle late is not granted again.
                ArbCool: state_q <= ArbIdle;
                default: state_q <= ArbIdle;
            endcase
        end
    end

    always_comb begin
        mem_enable_o = (state_q == ArbBusyI) || (state_q == ArbBusyD);
        mem_write_o  = mem_write_q;
        mem_addr_o   = mem_addr_q;
        mem_data_o   = mem_data_q;
        // Completion is routed only to the port that owns the transaction.
        ic_ack_o     = (state_q == ArbBusyI) && mem_ack_i;
        dc_ack_o     = (state_q == ArbBusyD) && mem_ack_i;
        ic_data_o    = mem_data_i;
        dc_data_o    = mem_data_i;
    end

endmodule
